// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/PC-select sequencer for the 5-stage pipeline: hazard priority,
// memory-wait timeout, interrupt pending latch and post-vector blackout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 15,
    parameter int IRQ_BLACKOUT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_valid,
    input  logic       id_kernel,
    input  logic       id_jump,
    input  logic       id_jr,
    input  logic       id_undef,
    input  logic       ex_memrd,
    input  logic [4:0] ex_rd_dst,
    input  logic       ex_branch_taken,
    input  logic       mem_busy,
    input  logic       irq,
    output logic       hold_pc,
    output logic       hold_if2id,
    output logic       hold_id2ex,
    output logic       hold_ex2mem,
    output logic       flush_if2id,
    output logic       flush_id2ex,
    output logic       flush_mem2wb,
    output logic [2:0] pc_sel,
    output logic       epc_we,
    output logic       bus_err
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, BUS_ERR, BLACKOUT} state_t;

    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [2:0] BLK_LOAD = 3'(IRQ_BLACKOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic [2:0] blk_cnt, blk_cnt_nxt;
    logic       irq_pend, irq_pend_nxt;
    logic       pre_blk, pre_blk_nxt;

    logic load_use, in_blk, stall, reload, take;

    assign load_use = ex_memrd && (ex_rd_dst != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd_dst)) ||
                       (id_uses_rt && (id_rt == ex_rd_dst)));

    // A wait that ends resumes the state it interrupted, blackout included.
    assign in_blk = (state == BLACKOUT) || ((state == MEM_WAIT) && pre_blk);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            blk_cnt  <= '0;
            irq_pend <= 1'b0;
            pre_blk  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            blk_cnt  <= blk_cnt_nxt;
            irq_pend <= irq_pend_nxt;
            pre_blk  <= pre_blk_nxt;
        end
    end

    always_comb begin
        hold_pc      = 1'b0;
        hold_if2id   = 1'b0;
        hold_id2ex   = 1'b0;
        hold_ex2mem  = 1'b0;
        flush_if2id  = 1'b0;
        flush_id2ex  = 1'b0;
        flush_mem2wb = 1'b0;
        pc_sel       = 3'd0;
        epc_we       = 1'b0;
        bus_err      = 1'b0;
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        blk_cnt_nxt  = blk_cnt;
        pre_blk_nxt  = pre_blk;
        stall        = 1'b0;
        reload       = 1'b0;
        take         = 1'b0;

        if (!reset) begin
            if (state == BUS_ERR) begin
                bus_err      = 1'b1;
                flush_if2id  = 1'b1;
                flush_id2ex  = 1'b1;
                flush_mem2wb = 1'b1;
                pc_sel       = 3'd5;
                epc_we       = 1'b1;
                state_nxt    = BLACKOUT;
                blk_cnt_nxt  = BLK_LOAD;
            end else if ((state == MEM_WAIT) && mem_busy) begin
                hold_pc      = 1'b1;
                hold_if2id   = 1'b1;
                hold_id2ex   = 1'b1;
                hold_ex2mem  = 1'b1;
                flush_mem2wb = 1'b1;
                if (wait_cnt == TIMEOUT) begin
                    state_nxt    = BUS_ERR;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != 8'hFF) begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end else begin
                state_nxt    = in_blk ? BLACKOUT : RUN;
                wait_cnt_nxt = '0;
                if (mem_busy) begin
                    hold_pc      = 1'b1;
                    hold_if2id   = 1'b1;
                    hold_id2ex   = 1'b1;
                    hold_ex2mem  = 1'b1;
                    flush_mem2wb = 1'b1;
                    stall        = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                    pre_blk_nxt  = in_blk;
                end else if (ex_branch_taken) begin
                    flush_if2id = 1'b1;
                    flush_id2ex = 1'b1;
                    pc_sel      = 3'd1;
                end else if (load_use) begin
                    hold_pc     = 1'b1;
                    hold_if2id  = 1'b1;
                    flush_id2ex = 1'b1;
                    stall       = 1'b1;
                end else if (id_valid && id_undef) begin
                    flush_if2id = 1'b1;
                    flush_id2ex = 1'b1;
                    pc_sel      = 3'd5;
                    epc_we      = 1'b1;
                    reload      = 1'b1;
                end else if (id_valid && irq_pend && !in_blk && !id_kernel) begin
                    flush_if2id = 1'b1;
                    flush_id2ex = 1'b1;
                    pc_sel      = 3'd4;
                    epc_we      = 1'b1;
                    reload      = 1'b1;
                    take        = 1'b1;
                end else if (id_jr) begin
                    flush_if2id = 1'b1;
                    pc_sel      = 3'd3;
                end else if (id_jump) begin
                    flush_if2id = 1'b1;
                    pc_sel      = 3'd2;
                end

                // Blackout only counts down on cycles where the pipe advances.
                if (reload) begin
                    state_nxt   = BLACKOUT;
                    blk_cnt_nxt = BLK_LOAD;
                end else if (in_blk && !stall) begin
                    if (blk_cnt <= 3'd1) begin
                        state_nxt   = RUN;
                        blk_cnt_nxt = '0;
                    end else begin
                        blk_cnt_nxt = blk_cnt - 3'd1;
                    end
                end
            end
        end

        if (take)                 irq_pend_nxt = 1'b0;
        else if (irq && !id_kernel) irq_pend_nxt = 1'b1;
        else                      irq_pend_nxt = irq_pend;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: single-cycle vector table, directed multi-cycle
// sequences, and random traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int MEM_TIMEOUT  = 15;
    localparam int IRQ_BLACKOUT = 2;

    // {hold_pc,hold_if2id,hold_id2ex,hold_ex2mem,flush_if2id,flush_id2ex,
    //  flush_mem2wb,pc_sel[2:0],epc_we,bus_err}
    localparam logic [11:0] NONE  = 12'h000;
    localparam logic [11:0] STALL = 12'hF20;
    localparam logic [11:0] LU    = 12'hC40;
    localparam logic [11:0] BR    = 12'h0C4;
    localparam logic [11:0] EXC   = 12'h0D6;
    localparam logic [11:0] IRQV  = 12'h0D2;
    localparam logic [11:0] BERR  = 12'h0F7;
    localparam logic [11:0] JMP   = 12'h088;
    localparam logic [11:0] JR    = 12'h08C;

    typedef struct packed {
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rs;
        logic       id_uses_rt;
        logic       id_valid;
        logic       id_kernel;
        logic       id_jump;
        logic       id_jr;
        logic       id_undef;
        logic       ex_memrd;
        logic [4:0] ex_rd_dst;
        logic       ex_branch_taken;
        logic       mem_busy;
        logic       irq;
    } in_t;

    typedef struct {
        in_t         v;
        logic [11:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  vin = '0;
    logic hold_pc, hold_if2id, hold_id2ex, hold_ex2mem;
    logic flush_if2id, flush_id2ex, flush_mem2wb, epc_we, bus_err;
    logic [2:0] pc_sel;
    logic [11:0] got;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    bit m_pend, m_err;
    int m_blk, m_streak;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .IRQ_BLACKOUT(IRQ_BLACKOUT)) dut (
        .clk(clk), .reset(reset),
        .id_rs(vin.id_rs), .id_rt(vin.id_rt),
        .id_uses_rs(vin.id_uses_rs), .id_uses_rt(vin.id_uses_rt),
        .id_valid(vin.id_valid), .id_kernel(vin.id_kernel),
        .id_jump(vin.id_jump), .id_jr(vin.id_jr), .id_undef(vin.id_undef),
        .ex_memrd(vin.ex_memrd), .ex_rd_dst(vin.ex_rd_dst),
        .ex_branch_taken(vin.ex_branch_taken), .mem_busy(vin.mem_busy), .irq(vin.irq),
        .hold_pc(hold_pc), .hold_if2id(hold_if2id), .hold_id2ex(hold_id2ex),
        .hold_ex2mem(hold_ex2mem), .flush_if2id(flush_if2id), .flush_id2ex(flush_id2ex),
        .flush_mem2wb(flush_mem2wb), .pc_sel(pc_sel), .epc_we(epc_we), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign got = {hold_pc, hold_if2id, hold_id2ex, hold_ex2mem, flush_if2id,
                  flush_id2ex, flush_mem2wb, pc_sel, epc_we, bus_err};

    task automatic check(input string name, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%03h expected=%03h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_err = 0; m_blk = 0; m_streak = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vin   = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drive at posedge+1, compare at posedge+3, then advance one cycle.
    task automatic step(input in_t v, input logic [11:0] exp, input string name);
        vin = v;
        #2;
        check(name, exp);
        @(posedge clk); #1;
    endtask

    // Expected outputs for this cycle; advances the model to the next cycle.
    task automatic model_step(input in_t v, output logic [11:0] e);
        bit blk, stall, reload, take, lu;
        e = NONE; stall = 0; reload = 0; take = 0;
        lu = v.ex_memrd && v.ex_rd_dst != 0 &&
             ((v.id_uses_rs && v.id_rs == v.ex_rd_dst) || (v.id_uses_rt && v.id_rt == v.ex_rd_dst));
        if (m_err) begin
            e = BERR; m_err = 0; m_blk = IRQ_BLACKOUT;
        end else if (m_streak > 0 && v.mem_busy) begin
            e = STALL;
            if (m_streak == MEM_TIMEOUT) begin m_err = 1; m_streak = 0; end
            else if (m_streak < 255) m_streak++;
        end else begin
            blk = (m_blk > 0);
            m_streak = 0;
            if (v.mem_busy)                                     begin e = STALL; m_streak = 1; stall = 1; end
            else if (v.ex_branch_taken)                         e = BR;
            else if (lu)                                        begin e = LU; stall = 1; end
            else if (v.id_valid && v.id_undef)                  begin e = EXC; reload = 1; end
            else if (v.id_valid && m_pend && !blk && !v.id_kernel) begin e = IRQV; reload = 1; take = 1; end
            else if (v.id_jr)                                   e = JR;
            else if (v.id_jump)                                 e = JMP;
            if (reload)              m_blk = IRQ_BLACKOUT;
            else if (blk && !stall)  m_blk--;
        end
        if (take)                         m_pend = 0;
        else if (v.irq && !v.id_kernel)   m_pend = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        in_t  t;
        logic [11:0] e;
        int   berr_cnt, burst;

        // Reset state
        vin = '0;
        #2;
        check("reset_outputs", NONE);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        t = '0;                                                                  tbl.push_back('{t, NONE, "idle"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=8; t.id_rs=8; t.id_uses_rs=1;          tbl.push_back('{t, LU, "loaduse_rs"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=0; t.id_rs=0; t.id_uses_rs=1;          tbl.push_back('{t, NONE, "loaduse_r0"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=9; t.id_rt=9; t.id_uses_rt=1;          tbl.push_back('{t, LU, "loaduse_rt"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=9; t.id_rt=9; t.id_uses_rt=0;          tbl.push_back('{t, NONE, "loaduse_rt_unused"});
        t = '0; t.ex_memrd=0; t.ex_rd_dst=8; t.id_rs=8; t.id_uses_rs=1;          tbl.push_back('{t, NONE, "no_load_match"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=8; t.id_rs=8; t.id_uses_rs=1; t.ex_branch_taken=1;
                                                                                 tbl.push_back('{t, BR, "branch_over_loaduse"});
        t = '0; t.mem_busy=1; t.ex_branch_taken=1;                               tbl.push_back('{t, STALL, "busy_over_branch"});
        t = '0; t.id_valid=1; t.id_undef=1;                                      tbl.push_back('{t, EXC, "undef"});
        t = '0; t.id_valid=0; t.id_undef=1;                                      tbl.push_back('{t, NONE, "undef_bubble"});
        t = '0; t.id_jump=1;                                                     tbl.push_back('{t, JMP, "jump"});
        t = '0; t.id_jump=1; t.id_jr=1;                                          tbl.push_back('{t, JR, "jr_over_jump"});
        t = '0; t.ex_memrd=1; t.ex_rd_dst=3; t.id_rt=3; t.id_uses_rt=1; t.id_valid=1; t.id_undef=1;
                                                                                 tbl.push_back('{t, LU, "loaduse_over_undef"});
        t = '0; t.id_valid=1; t.id_undef=1; t.id_jr=1;                           tbl.push_back('{t, EXC, "undef_over_jr"});

        foreach (tbl[i]) begin
            do_reset();
            step(tbl[i].v, tbl[i].exp, tbl[i].name);
        end

        // Memory wait with a branch frozen in EX
        do_reset();
        t = '0; t.mem_busy = 1; t.ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) step(t, STALL, "memwait_hold");
        t.mem_busy = 0;
        step(t, BR, "memwait_release_branch");
        step('0, NONE, "memwait_after");

        // Timeout: exactly one bus_err after MEM_TIMEOUT counted wait cycles
        do_reset();
        berr_cnt = 0;
        t = '0; t.mem_busy = 1;
        for (int i = 0; i < 20; i++) begin
            vin = t;
            #2;
            if (bus_err === 1'b1) berr_cnt++;
            check($sformatf("timeout_c%0d", i), (i == MEM_TIMEOUT + 1) ? BERR : STALL);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (berr_cnt != 1) begin
            n_err++;
            $display("FAIL timeout_pulse_count: got=%0d expected=1", berr_cnt);
        end
        do_reset();

        // Interrupt taken when ID is valid, then deferred through blackout
        t = '0; t.irq = 1;                step(t, NONE, "irq_latch");
        t = '0;                           step(t, NONE, "irq_wait1");
                                          step(t, NONE, "irq_wait2");
        t = '0; t.id_valid = 1;           step(t, IRQV, "irq_taken");
        t = '0; t.id_valid = 1; t.irq = 1; step(t, NONE, "irq_blackout1");
        t = '0; t.id_valid = 1;           step(t, NONE, "irq_blackout2");
                                          step(t, IRQV, "irq_after_blackout");
                                          step(t, NONE, "irq_cleared");

        // Kernel masking
        do_reset();
        t = '0; t.irq = 1; t.id_kernel = 1; t.id_valid = 1;
        step(t, NONE, "kernel_mask1");
        step(t, NONE, "kernel_mask2");
        t = '0; t.id_valid = 1;
        step(t, NONE, "kernel_no_pend");

        // Reset during a memory wait clears everything at once
        do_reset();
        t = '0; t.mem_busy = 1;
        for (int i = 0; i < 3; i++) step(t, STALL, "pre_reset_wait");
        reset = 1'b1;
        #1;
        check("reset_midwait", NONE);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        step('0, NONE, "post_reset_idle");
        t = '0; t.ex_branch_taken = 1;
        step(t, BR, "post_reset_branch");

        // Random traffic against the model
        do_reset();
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            t = '0;
            t.id_rs           = 5'($urandom_range(0, 3));
            t.id_rt           = 5'($urandom_range(0, 3));
            t.id_uses_rs      = 1'($urandom_range(0, 1));
            t.id_uses_rt      = 1'($urandom_range(0, 1));
            t.id_valid        = ($urandom_range(0, 3) != 0);
            t.id_kernel       = ($urandom_range(0, 5) == 0);
            t.id_jump         = ($urandom_range(0, 7) == 0);
            t.id_jr           = ($urandom_range(0, 7) == 0);
            t.id_undef        = ($urandom_range(0, 15) == 0);
            t.ex_memrd        = ($urandom_range(0, 3) == 0);
            t.ex_rd_dst       = 5'($urandom_range(0, 3));
            t.ex_branch_taken = ($urandom_range(0, 7) == 0);
            t.irq             = ($urandom_range(0, 9) == 0);
            if (burst == 0 && $urandom_range(0, 63) == 0) burst = $urandom_range(10, 20);
            t.mem_busy = (burst > 0) || ($urandom_range(0, 9) == 0);
            if (burst > 0) burst--;
            model_step(t, e);
            step(t, e, $sformatf("random_c%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
